truth_table_scanner: RTL



---
 rtl/truth_table_scanner.sv | 136 +++++++++++++
 1 files changed

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: steps an N-input combinational gate through every input
// combination, samples its 1-bit response after a settle window, assembles the
// truth table and compares it against a golden table.
module truth_table_scanner #(
    parameter int N_INPUTS      = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [(1<<N_INPUTS)-1:0] expected,
    input  logic                  resp,
    output logic [N_INPUTS-1:0]   stim,
    output logic                  busy,
    output logic                  done,
    output logic [(1<<N_INPUTS)-1:0] table_out,
    output logic                  pass,
    output logic [N_INPUTS-1:0]   fail_index
);

    localparam int W     = 1 << N_INPUTS;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [N_INPUTS-1:0]   stim_q, stim_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [W-1:0]          table_q, table_d;
    logic [W-1:0]          exp_q, exp_d;
    logic                  pass_q, pass_d;
    logic [N_INPUTS-1:0]   fidx_q, fidx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Lowest set bit of a difference vector; zero when no bit differs.
    function automatic logic [N_INPUTS-1:0] lowest_diff(input logic [W-1:0] diff);
        logic [N_INPUTS-1:0] idx;
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (diff[i]) idx = N_INPUTS'(i);
        end
        return idx;
    endfunction

    // Next-state logic: scan sequencing, table capture and verdict at the final window.
    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        table_d = table_q;
        exp_d   = exp_q;
        pass_d  = pass_q;
        fidx_d  = fidx_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, FINISH: begin
                state_d = IDLE;
                if (start) begin
                    state_d = SCAN;
                    busy_d  = 1'b1;
                    stim_d  = '0;
                    cnt_d   = '0;
                    exp_d   = expected;
                    table_d = '0;
                    pass_d  = 1'b0;
                    fidx_d  = '0;
                end
            end
            SCAN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    table_d[stim_q] = resp;
                    if (stim_q == '1) begin
                        // Last combination: verdict is registered together with entry to FINISH
                        state_d = FINISH;
                        stim_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (table_d == exp_q);
                        fidx_d  = lowest_diff(table_d ^ exp_q);
                    end else begin
                        stim_d = stim_q + N_INPUTS'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                stim_d  = '0;
            end
        endcase
    end

    // State register with synchronous reset clearing every output and the scan position.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            exp_q   <= '0;
            pass_q  <= 1'b0;
            fidx_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            table_q <= table_d;
            exp_q   <= exp_d;
            pass_q  <= pass_d;
            fidx_q  <= fidx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stim       = stim_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign table_out  = table_q;
    assign pass       = pass_q;
    assign fail_index = fidx_q;

endmodule
